lap_stopwatch_core: RTL

//  Single-clock mm:ss stopwatch/timer core with a LAP_DEPTH-entry circular lap buffer, count-up and count-down modes.

---
 rtl/stopwatch_pkg.sv | 46 ++++
 rtl/bcd_mmss_counter.sv | 94 +++++++++
 rtl/lap_stopwatch_core.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the mm:ss lap stopwatch.
//   sw_state_t  : top-level control state
//   bcd_time_t  : packed BCD time {ten_m, one_m, ten_s, one_s}
//   TIME_ZERO   : 00:00
//   MAX_TIME    : 59:59
//   bcd_clamp() : forces an arbitrary 16-bit value into a legal mm:ss BCD time
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } sw_state_t;

    typedef struct packed {
        logic [3:0] ten_m;
        logic [3:0] one_m;
        logic [3:0] ten_s;
        logic [3:0] one_s;
    } bcd_time_t;

    localparam bcd_time_t TIME_ZERO = 16'h0000;
    localparam bcd_time_t MAX_TIME  = 16'h5959;

    // An out-of-range tens digit saturates its whole field (mm or ss) to 59,
    // so 00:A7 becomes 00:59. Otherwise an out-of-range units digit clamps to 9.
    function automatic bcd_time_t bcd_clamp(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.ten_s > 4'd5) begin
            r.ten_s = 4'd5;
            r.one_s = 4'd9;
        end else if (t.one_s > 4'd9) begin
            r.one_s = 4'd9;
        end
        if (t.ten_m > 4'd5) begin
            r.ten_m = 4'd5;
            r.one_m = 4'd9;
        end else if (t.one_m > 4'd9) begin
            r.one_m = 4'd9;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_mmss_counter.sv
// BCD mm:ss up/down counter with full ripple of carry/borrow in one cycle.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   clr           synchronous clear to 00:00 (highest priority)
//   load/load_val synchronous load of a BCD time
//   en            step one second this cycle
//   down          step direction (1 = count down)
//   value         current BCD time
//   zero          value is 00:00
//   step_to_zero  a step taken now would land on 00:00
module bcd_mmss_counter
    import stopwatch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        en,
    input  logic        down,
    output logic [15:0] value,
    output logic        zero,
    output logic        step_to_zero
);

    bcd_time_t value_q;
    bcd_time_t stepped;

    // Next value one second away; 59:59 wraps to 00:00 going up and
    // 00:00 wraps to 59:59 going down.
    always_comb begin
        stepped = value_q;
        if (down) begin
            if (value_q.one_s != 4'd0) begin
                stepped.one_s = value_q.one_s - 4'd1;
            end else begin
                stepped.one_s = 4'd9;
                if (value_q.ten_s != 4'd0) begin
                    stepped.ten_s = value_q.ten_s - 4'd1;
                end else begin
                    stepped.ten_s = 4'd5;
                    if (value_q.one_m != 4'd0) begin
                        stepped.one_m = value_q.one_m - 4'd1;
                    end else begin
                        stepped.one_m = 4'd9;
                        if (value_q.ten_m != 4'd0) begin
                            stepped.ten_m = value_q.ten_m - 4'd1;
                        end else begin
                            stepped.ten_m = 4'd5;
                        end
                    end
                end
            end
        end else begin
            if (value_q.one_s < 4'd9) begin
                stepped.one_s = value_q.one_s + 4'd1;
            end else begin
                stepped.one_s = 4'd0;
                if (value_q.ten_s < 4'd5) begin
                    stepped.ten_s = value_q.ten_s + 4'd1;
                end else begin
                    stepped.ten_s = 4'd0;
                    if (value_q.one_m < 4'd9) begin
                        stepped.one_m = value_q.one_m + 4'd1;
                    end else begin
                        stepped.one_m = 4'd0;
                        if (value_q.ten_m < 4'd5) begin
                            stepped.ten_m = value_q.ten_m + 4'd1;
                        end else begin
                            stepped.ten_m = 4'd0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= TIME_ZERO;
        end else if (clr) begin
            value_q <= TIME_ZERO;
        end else if (load) begin
            value_q <= bcd_time_t'(load_val);
        end else if (en) begin
            value_q <= stepped;
        end
    end

    assign value        = value_q;
    assign zero         = (value_q == TIME_ZERO);
    assign step_to_zero = (stepped == TIME_ZERO);

endmodule

// File: rtl/lap_stopwatch_core.sv
// Single-clock mm:ss stopwatch/timer core with a circular lap buffer.
// A clock-enable prescaler produces the 1 s tick; all control inputs are
// one-cycle pulses from the debounce front end.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start_stop   pulse: IDLE/PAUSE -> RUN, RUN -> PAUSE
//   lap          pulse: capture live time (RUN only)
//   clear        pulse: back to IDLE, zero time, empty lap buffer
//   mode_down    countdown select, sampled when leaving IDLE
//   preset       BCD countdown start value (clamped to legal mm:ss)
//   view_next    pulse: advance lap view index, wraps over stored laps
//   disp_sel     0 = live time, 1 = lap[view_idx]
//   disp         BCD time to display
//   running      1 in RUN
//   expired      1 in EXPIRED
//   lap_cnt      number of valid laps, saturates at LAP_DEPTH
//   view_idx     displayed lap index, 0 = oldest valid
//   lap_ovf      sticky: lap captured while buffer full
//   state_dbg    current control state (sw_state_t encoding)
//
// Handshake: there is no flow control; every input pulse is acted on in the
// cycle it is high, with same-cycle priority clear > start_stop > lap > view_next.
module lap_stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int  TICK_DIV  = 100_000_000,
    parameter int  LAP_DEPTH = 4,
    localparam int LAP_AW    = $clog2(LAP_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_stop,
    input  logic              lap,
    input  logic              clear,
    input  logic              mode_down,
    input  logic [15:0]       preset,
    input  logic              view_next,
    input  logic              disp_sel,
    output logic [15:0]       disp,
    output logic              running,
    output logic              expired,
    output logic [LAP_AW:0]   lap_cnt,
    output logic [LAP_AW-1:0] view_idx,
    output logic              lap_ovf,
    output logic [1:0]        state_dbg
);

    localparam int                 PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]      PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [LAP_AW:0]    LAP_FULL   = (LAP_AW + 1)'(LAP_DEPTH);

    sw_state_t         state_q, state_d;
    logic              mode_down_q;
    logic [PW-1:0]     presc_q;
    logic              tick;

    bcd_time_t         preset_c;
    logic [15:0]       live;
    logic              live_zero;
    logic              live_step_to_zero;

    logic              cnt_clr, cnt_load, cnt_en;
    logic              presc_clr, presc_inc, mode_latch;
    logic              lap_we, view_adv, clear_laps;

    logic [15:0]       lap_ram [LAP_DEPTH];
    logic [LAP_AW-1:0] wr_ptr_q;
    logic [LAP_AW:0]   lap_cnt_q;
    logic [LAP_AW-1:0] view_idx_q;
    logic              lap_ovf_q;
    logic              lap_full;
    logic [LAP_AW:0]   view_plus;
    logic [LAP_AW-1:0] rd_addr;

    assign preset_c = bcd_clamp(bcd_time_t'(preset));
    assign tick     = (state_q == RUN) && (presc_q == PRESC_LAST);
    assign lap_full = (lap_cnt_q == LAP_FULL);

    bcd_mmss_counter u_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (cnt_clr),
        .load         (cnt_load),
        .load_val     (mode_down ? preset_c : TIME_ZERO),
        .en           (cnt_en),
        .down         (mode_down_q),
        .value        (live),
        .zero         (live_zero),
        .step_to_zero (live_step_to_zero)
    );

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_clr    = 1'b0;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        presc_clr  = 1'b0;
        presc_inc  = 1'b0;
        mode_latch = 1'b0;
        lap_we     = 1'b0;
        view_adv   = 1'b0;
        clear_laps = 1'b0;

        if (clear) begin
            state_d    = IDLE;
            cnt_clr    = 1'b1;
            presc_clr  = 1'b1;
            clear_laps = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_stop) begin
                        cnt_load   = 1'b1;
                        presc_clr  = 1'b1;
                        mode_latch = 1'b1;
                        state_d    = (mode_down && preset_c == TIME_ZERO) ? EXPIRED : RUN;
                    end else begin
                        view_adv = view_next;
                    end
                end
                RUN: begin
                    // The prescaler advances in every RUN cycle, including the
                    // one in which start_stop pauses the count.
                    presc_inc = 1'b1;
                    cnt_en    = tick;
                    // Reaching 00:00 in countdown wins over a same-cycle pause.
                    if (mode_down_q && (live_zero || (tick && live_step_to_zero))) begin
                        state_d = EXPIRED;
                    end else if (start_stop) begin
                        state_d = PAUSE;
                    end
                    if (!start_stop) begin
                        if (lap) begin
                            lap_we = 1'b1;
                        end else begin
                            view_adv = view_next;
                        end
                    end
                end
                PAUSE: begin
                    if (start_stop) begin
                        state_d = RUN;
                    end else begin
                        view_adv = view_next;
                    end
                end
                default: begin
                    // EXPIRED waits for clear only.
                end
            endcase
        end
    end

    // ---------------- prescaler and mode latch ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q     <= '0;
            mode_down_q <= 1'b0;
        end else begin
            if (presc_clr) begin
                presc_q <= '0;
            end else if (presc_inc) begin
                presc_q <= tick ? '0 : presc_q + PW'(1);
            end
            if (clear) begin
                mode_down_q <= 1'b0;
            end else if (mode_latch) begin
                mode_down_q <= mode_down;
            end
        end
    end

    // ---------------- lap bookkeeping ----------------
    assign view_plus = {1'b0, view_idx_q} + (LAP_AW + 1)'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            lap_cnt_q  <= '0;
            view_idx_q <= '0;
            lap_ovf_q  <= 1'b0;
        end else if (clear_laps) begin
            wr_ptr_q   <= '0;
            lap_cnt_q  <= '0;
            view_idx_q <= '0;
            lap_ovf_q  <= 1'b0;
        end else begin
            if (lap_we) begin
                wr_ptr_q <= wr_ptr_q + LAP_AW'(1);
                if (lap_full) begin
                    lap_ovf_q <= 1'b1;
                end else begin
                    lap_cnt_q <= lap_cnt_q + (LAP_AW + 1)'(1);
                end
            end
            if (view_adv && lap_cnt_q != '0) begin
                view_idx_q <= (view_plus >= lap_cnt_q) ? '0 : view_plus[LAP_AW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAP_DEPTH; i++) begin
                lap_ram[i] <= '0;
            end
        end else if (lap_we) begin
            lap_ram[wr_ptr_q] <= live;
        end
    end

    // Once the buffer has wrapped, the oldest entry sits at the write pointer.
    assign rd_addr = (lap_full ? wr_ptr_q : '0) + view_idx_q;

    // ---------------- outputs ----------------
    always_comb begin
        disp = live;
        if (disp_sel) begin
            disp = (lap_cnt_q == '0) ? TIME_ZERO : lap_ram[rd_addr];
        end
    end

    assign running   = (state_q == RUN);
    assign expired   = (state_q == EXPIRED);
    assign lap_cnt   = lap_cnt_q;
    assign view_idx  = view_idx_q;
    assign lap_ovf   = lap_ovf_q;
    assign state_dbg = state_q;

endmodule
